// File: rtl/mpu6050_pkg.sv
// Shared MPU-6050 definitions: bus address, register map, FSM states.
// Used by the responder and the matching controller.
package mpu6050_pkg;

    localparam logic [6:0] DEV_ADDR_DEFAULT = 7'h68;

    localparam logic [7:0] ACCEL_XOUT_H = 8'h3B;
    localparam logic [7:0] ACCEL_XOUT_L = 8'h3C;
    localparam logic [7:0] ACCEL_YOUT_H = 8'h3D;
    localparam logic [7:0] ACCEL_YOUT_L = 8'h3E;
    localparam logic [7:0] ACCEL_ZOUT_H = 8'h3F;
    localparam logic [7:0] ACCEL_ZOUT_L = 8'h40;
    localparam logic [7:0] PWR_MGMT_1   = 8'h6B;
    localparam logic [7:0] WHO_AM_I     = 8'h75;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ACK_A,
        ST_REG,
        ST_ACK_R,
        ST_WDATA,
        ST_ACK_W,
        ST_TX,
        ST_IGNORE
    } i2c_state_t;

endpackage

// File: rtl/i2c_bus_sync.sv
// I2C pad conditioning: 2-FF synchronizers, one history stage,
// SCL edge strobes and START/STOP detection.
module i2c_bus_sync (
    input  logic clk,
    input  logic reset,
    input  logic scl_in,
    input  logic sda_in,
    output logic scl_rise,
    output logic scl_fall,
    output logic sda_s,
    output logic start_det,
    output logic stop_det
);

    logic [1:0] scl_ff;
    logic [1:0] sda_ff;
    logic       scl_q;
    logic       sda_q;
    logic       scl_s;

    // Synchronize both lines; reset to the idle (released-high) bus level.
    always_ff @(posedge clk) begin
        if (reset) begin
            scl_ff <= 2'b11;
            sda_ff <= 2'b11;
            scl_q  <= 1'b1;
            sda_q  <= 1'b1;
        end else begin
            scl_ff <= {scl_ff[0], scl_in};
            sda_ff <= {sda_ff[0], sda_in};
            scl_q  <= scl_ff[1];
            sda_q  <= sda_ff[1];
        end
    end

    assign scl_s     = scl_ff[1];
    assign sda_s     = sda_ff[1];
    assign scl_rise  = scl_s & ~scl_q;
    assign scl_fall  = ~scl_s & scl_q;
    assign start_det = scl_s & scl_q & sda_q & ~sda_s;
    assign stop_det  = scl_s & scl_q & ~sda_q & sda_s;

endmodule

// File: rtl/mpu6050_i2c_responder.sv
// I2C target emulating the MPU-6050 accel/WHO_AM_I/PWR_MGMT_1 subset.
// SDA is open-drain: sda_oe=1 pulls the line low.
module mpu6050_i2c_responder
    import mpu6050_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR     = DEV_ADDR_DEFAULT,
    parameter logic [7:0] WHO_AM_I_VAL = 8'h68,
    parameter logic [7:0] PWR_RST      = 8'h40
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        scl_in,
    input  logic        sda_in,
    output logic        sda_oe,
    input  logic [15:0] accel_x,
    input  logic [15:0] accel_y,
    input  logic [15:0] accel_z,
    output logic [7:0]  pwr_mgmt_1,
    output logic        wr_strobe,
    output logic [7:0]  wr_addr,
    output logic [7:0]  wr_data,
    output logic        busy
);

    logic scl_rise;
    logic scl_fall;
    logic sda_s;
    logic start_det;
    logic stop_det;

    i2c_bus_sync u_sync (
        .clk       (clk),
        .reset     (reset),
        .scl_in    (scl_in),
        .sda_in    (sda_in),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .sda_s     (sda_s),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    i2c_state_t  state, state_d;
    logic [3:0]  cnt, cnt_d;
    logic [7:0]  sh, sh_d;
    logic [7:0]  reg_ptr, reg_ptr_d;
    logic [47:0] shadow, shadow_d;
    logic        rw, rw_d;
    logic        oe_d;
    logic [7:0]  pwr_d;
    logic        strb_d;
    logic [7:0]  waddr_d;
    logic [7:0]  wdata_d;
    logic        busy_d;
    logic [7:0]  rd_byte;
    logic [2:0]  bit_idx;
    logic [7:0]  sh_next;

    // Register-map read mux, served from the burst snapshot.
    always_comb begin
        rd_byte = 8'h00;
        unique case (reg_ptr)
            ACCEL_XOUT_H: rd_byte = shadow[47:40];
            ACCEL_XOUT_L: rd_byte = shadow[39:32];
            ACCEL_YOUT_H: rd_byte = shadow[31:24];
            ACCEL_YOUT_L: rd_byte = shadow[23:16];
            ACCEL_ZOUT_H: rd_byte = shadow[15:8];
            ACCEL_ZOUT_L: rd_byte = shadow[7:0];
            PWR_MGMT_1:   rd_byte = pwr_mgmt_1;
            WHO_AM_I:     rd_byte = WHO_AM_I_VAL;
            default:      rd_byte = 8'h00;
        endcase
    end

    assign bit_idx = ~cnt[2:0];
    assign sh_next = {sh[6:0], sda_s};

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            cnt        <= 4'd0;
            sh         <= 8'h00;
            reg_ptr    <= 8'h00;
            shadow     <= 48'h0;
            rw         <= 1'b0;
            sda_oe     <= 1'b0;
            pwr_mgmt_1 <= PWR_RST;
            wr_strobe  <= 1'b0;
            wr_addr    <= 8'h00;
            wr_data    <= 8'h00;
            busy       <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            sh         <= sh_d;
            reg_ptr    <= reg_ptr_d;
            shadow     <= shadow_d;
            rw         <= rw_d;
            sda_oe     <= oe_d;
            pwr_mgmt_1 <= pwr_d;
            wr_strobe  <= strb_d;
            wr_addr    <= waddr_d;
            wr_data    <= wdata_d;
            busy       <= busy_d;
        end
    end

    // Bus protocol: bits taken on SCL rise, SDA drive changed on SCL fall.
    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        sh_d      = sh;
        reg_ptr_d = reg_ptr;
        shadow_d  = shadow;
        rw_d      = rw;
        oe_d      = sda_oe;
        pwr_d     = pwr_mgmt_1;
        strb_d    = 1'b0;
        waddr_d   = wr_addr;
        wdata_d   = wr_data;
        busy_d    = busy;
        if (start_det) begin
            state_d = ST_ADDR;
            cnt_d   = 4'd0;
            oe_d    = 1'b0;
        end else if (stop_det) begin
            state_d = ST_IDLE;
            oe_d    = 1'b0;
            busy_d  = 1'b0;
        end else begin
            unique case (state)
                ST_ADDR: begin
                    if (scl_rise) begin
                        sh_d  = sh_next;
                        cnt_d = cnt + 4'd1;
                        if (cnt == 4'd7) begin
                            if (sh[6:0] == DEV_ADDR) begin
                                state_d = ST_ACK_A;
                                rw_d    = sda_s;
                                busy_d  = 1'b1;
                            end else begin
                                state_d = ST_IGNORE;
                            end
                        end
                    end
                end
                ST_ACK_A: begin
                    if (scl_fall) oe_d = 1'b1;
                    if (scl_rise) begin
                        cnt_d = 4'd0;
                        if (rw) begin
                            shadow_d = {accel_x, accel_y, accel_z};
                            state_d  = ST_TX;
                        end else begin
                            state_d  = ST_REG;
                        end
                    end
                end
                ST_REG: begin
                    if (scl_fall) oe_d = 1'b0;
                    if (scl_rise) begin
                        sh_d  = sh_next;
                        cnt_d = cnt + 4'd1;
                        if (cnt == 4'd7) begin
                            reg_ptr_d = sh_next;
                            state_d   = ST_ACK_R;
                        end
                    end
                end
                ST_ACK_R: begin
                    if (scl_fall) oe_d = 1'b1;
                    if (scl_rise) begin
                        cnt_d   = 4'd0;
                        state_d = ST_WDATA;
                    end
                end
                ST_WDATA: begin
                    if (scl_fall) oe_d = 1'b0;
                    if (scl_rise) begin
                        sh_d  = sh_next;
                        cnt_d = cnt + 4'd1;
                        if (cnt == 4'd7) state_d = ST_ACK_W;
                    end
                end
                ST_ACK_W: begin
                    if (scl_fall) oe_d = 1'b1;
                    if (scl_rise) begin
                        strb_d    = 1'b1;
                        waddr_d   = reg_ptr;
                        wdata_d   = sh;
                        if (reg_ptr == PWR_MGMT_1) pwr_d = sh;
                        reg_ptr_d = reg_ptr + 8'd1;
                        cnt_d     = 4'd0;
                        state_d   = ST_WDATA;
                    end
                end
                ST_TX: begin
                    if (scl_fall) begin
                        if (cnt < 4'd8) oe_d = ~rd_byte[bit_idx];
                        else            oe_d = 1'b0;
                    end
                    if (scl_rise) begin
                        if (cnt < 4'd8) begin
                            cnt_d = cnt + 4'd1;
                        end else if (!sda_s) begin
                            reg_ptr_d = reg_ptr + 8'd1;
                            cnt_d     = 4'd0;
                        end else begin
                            state_d = ST_IGNORE;
                        end
                    end
                end
                ST_IGNORE: oe_d = 1'b0;
                default:   oe_d = 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_mpu6050_i2c_responder.sv
// Bench for mpu6050_i2c_responder: bit-banged I2C master,
// scoreboard queues for write strobes and read bytes.
module tb_mpu6050_i2c_responder;

    localparam int T = 160;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        scl_m = 1'b1;
    logic        sda_m = 1'b1;
    logic        sda_oe;
    logic [15:0] accel_x = 16'h0;
    logic [15:0] accel_y = 16'h0;
    logic [15:0] accel_z = 16'h0;
    logic [7:0]  pwr_mgmt_1;
    logic        wr_strobe;
    logic [7:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        busy;
    wire         sda_line = sda_m & ~sda_oe;

    int n_chk = 0;
    int n_err = 0;

    logic [15:0] wr_exp[$];
    logic [7:0]  rd_exp[$];
    logic [7:0]  rd_obs[$];
    logic        oe_q = 1'b0;
    logic        oe_seen = 1'b0;

    mpu6050_i2c_responder dut (
        .clk        (clk),
        .reset      (reset),
        .scl_in     (scl_m),
        .sda_in     (sda_line),
        .sda_oe     (sda_oe),
        .accel_x    (accel_x),
        .accel_y    (accel_y),
        .accel_z    (accel_z),
        .pwr_mgmt_1 (pwr_mgmt_1),
        .wr_strobe  (wr_strobe),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy)
    );

    always #10 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: compares write strobes and read bytes.
    always @(negedge clk) begin
        if (wr_strobe === 1'b1) begin
            if (wr_exp.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL wr_unexpected: got addr %0h data %0h expected none",
                         wr_addr, wr_data);
            end else begin
                chk("wr_strobe", {16'h0, wr_addr, wr_data},
                    {16'h0, wr_exp.pop_front()});
            end
        end
        while (rd_obs.size() > 0) begin
            if (rd_exp.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL rd_unexpected: got %0h expected none",
                         rd_obs.pop_front());
            end else begin
                chk("rd_byte", {24'h0, rd_obs.pop_front()},
                    {24'h0, rd_exp.pop_front()});
            end
        end
    end

    // SDA drive may only change while SCL is low.
    always @(negedge clk) begin
        if (!reset && sda_oe !== oe_q) begin
            n_chk++;
            if (scl_m) begin
                n_err++;
                $display("FAIL oe_edge_scl_high: got change to %0b expected none",
                         sda_oe);
            end
        end
        if (sda_oe) oe_seen = 1'b1;
        oe_q = sda_oe;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic bit_out(input logic b);
        sda_m = b;
        #T scl_m = 1'b1;
        #(2*T) scl_m = 1'b0;
        #T;
    endtask

    task automatic bit_in(output logic b);
        sda_m = 1'b1;
        #T scl_m = 1'b1;
        #T b = sda_line;
        #T scl_m = 1'b0;
        #T;
    endtask

    task automatic i2c_start;
        sda_m = 1'b1;
        #T scl_m = 1'b1;
        #T sda_m = 1'b0;
        #T scl_m = 1'b0;
        #T;
    endtask

    task automatic i2c_stop;
        sda_m = 1'b0;
        #T scl_m = 1'b1;
        #T sda_m = 1'b1;
        #T;
    endtask

    task automatic wbyte(input logic [7:0] b, output logic ack);
        logic a;
        for (int i = 7; i >= 0; i--) bit_out(b[i]);
        bit_in(a);
        ack = ~a;
    endtask

    task automatic wr_ack(input string name, input logic [7:0] b,
                          input logic exp_ack);
        logic a;
        wbyte(b, a);
        chk(name, {31'h0, a}, {31'h0, exp_ack});
    endtask

    task automatic rbyte(input logic ack);
        logic [7:0] v;
        logic x;
        v = 8'h00;
        for (int i = 0; i < 8; i++) begin
            bit_in(x);
            v = {v[6:0], x};
        end
        rd_obs.push_back(v);
        bit_out(~ack);
    endtask

    task automatic set_ptr(input logic [7:0] r);
        i2c_start;
        wr_ack("ack_addr_w", 8'hD0, 1'b1);
        wr_ack("ack_reg", r, 1'b1);
    endtask

    task automatic read_from(input logic [7:0] r, input logic [47:0] vals,
                             input int n);
        logic [47:0] v;
        v = vals;
        for (int i = 0; i < n; i++) begin
            rd_exp.push_back(v[47:40]);
            v = v << 8;
        end
        set_ptr(r);
        i2c_start;
        wr_ack("ack_addr_r", 8'hD1, 1'b1);
        for (int i = 0; i < n; i++) rbyte(i < n - 1);
        i2c_stop;
    endtask

    initial begin
        logic x;
        repeat (4) @(posedge clk);
        #1;
        chk("rst_sda_oe", {31'h0, sda_oe}, 32'h0);
        chk("rst_pwr", {24'h0, pwr_mgmt_1}, 32'h40);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_strobe", {31'h0, wr_strobe}, 32'h0);
        chk("rst_wr_addr", {24'h0, wr_addr}, 32'h0);
        chk("rst_wr_data", {24'h0, wr_data}, 32'h0);
        reset = 1'b0;
        repeat (4) @(posedge clk);

        // Write PWR_MGMT_1 = 0x00
        i2c_start;
        wr_ack("t1_addr", 8'hD0, 1'b1);
        chk("t1_busy", {31'h0, busy}, 32'h1);
        wr_ack("t1_reg", 8'h6B, 1'b1);
        wr_exp.push_back(16'h6B00);
        wr_ack("t1_data", 8'h00, 1'b1);
        i2c_stop;
        #T;
        chk("t1_pwr", {24'h0, pwr_mgmt_1}, 32'h00);
        chk("t1_busy_stop", {31'h0, busy}, 32'h0);

        // Six-byte accel burst
        accel_x = 16'h1234;
        accel_y = 16'hFEDC;
        accel_z = 16'h4000;
        read_from(8'h3B, 48'h1234_FEDC_4000, 6);

        // Mid-burst change invisible, next burst sees it
        rd_exp.push_back(8'h12);
        rd_exp.push_back(8'h34);
        rd_exp.push_back(8'hFE);
        rd_exp.push_back(8'hDC);
        rd_exp.push_back(8'h40);
        rd_exp.push_back(8'h00);
        set_ptr(8'h3B);
        i2c_start;
        wr_ack("t3_addr_r", 8'hD1, 1'b1);
        rbyte(1'b1);
        accel_x = 16'hAAAA;
        for (int i = 0; i < 5; i++) rbyte(i < 4);
        i2c_stop;
        read_from(8'h3B, 48'hAAAA_FEDC_4000, 6);

        // Foreign address: silent
        oe_seen = 1'b0;
        i2c_start;
        wr_ack("t4_addr", 8'hD2, 1'b0);
        chk("t4_busy", {31'h0, busy}, 32'h0);
        wr_ack("t4_reg", 8'h6B, 1'b0);
        wr_ack("t4_data", 8'h55, 1'b0);
        i2c_stop;
        chk("t4_oe_seen", {31'h0, oe_seen}, 32'h0);
        chk("t4_pwr", {24'h0, pwr_mgmt_1}, 32'h00);

        // WHO_AM_I, PWR_MGMT_1, pointer wrap on read and write
        read_from(8'h75, 48'h68_0000000000, 1);
        read_from(8'h6B, 48'h00_0000000000, 1);
        read_from(8'hFF, 48'h0000_00000000, 2);
        i2c_start;
        wr_ack("t5_addr", 8'hD0, 1'b1);
        wr_ack("t5_reg", 8'hFF, 1'b1);
        wr_exp.push_back(16'hFFA5);
        wr_ack("t5_d0", 8'hA5, 1'b1);
        wr_exp.push_back(16'h005A);
        wr_ack("t5_d1", 8'h5A, 1'b1);
        i2c_stop;

        // Reset during byte 3 of a read
        accel_x = 16'h1234;
        accel_y = 16'h0000;
        rd_exp.push_back(8'h12);
        rd_exp.push_back(8'h34);
        set_ptr(8'h3B);
        i2c_start;
        wr_ack("t6_addr_r", 8'hD1, 1'b1);
        rbyte(1'b1);
        rbyte(1'b1);
        for (int i = 0; i < 3; i++) bit_in(x);
        chk("t6_bit3", {31'h0, x}, 32'h0);
        chk("t6_oe_pre", {31'h0, sda_oe}, 32'h1);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        chk("t6_oe_rst", {31'h0, sda_oe}, 32'h0);
        chk("t6_pwr_rst", {24'h0, pwr_mgmt_1}, 32'h40);
        chk("t6_busy_rst", {31'h0, busy}, 32'h0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        i2c_stop;
        read_from(8'h3B, 48'h1234_0000_0000, 2);
        read_from(8'h6B, 48'h40_0000000000, 1);

        repeat (20) @(posedge clk);
        chk("wr_queue_empty", wr_exp.size(), 32'h0);
        chk("rd_queue_empty", rd_exp.size(), 32'h0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
